bram_bist_ctrl: RTL and testbench
=================================

BRAM_BIST_CTRL -- requirements
Module: bram_bist_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: RAM word width, 1..128.
REQ-002 Parameter ADDR_WIDTH, default 4: RAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-003 Parameter BYTEEN_WIDTH, default 2: byte-enable width, DATA_WIDTH/8 rounded up.
REQ-004 Parameter READ_LATENCY, default 1: cycles from re to valid rdata, 1 (no output register) or 2 (output register).
REQ-005 Parameter LFSR_SEED, default 32'h1: nonzero seed for the pseudo-random pattern.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  run request, sampled in IDLE only.
REQ-009 pattern_mask  in  4  pattern enables: bit0 address, bit1 checkerboard, bit2 inverse checkerboard, bit3 LFSR.
REQ-010 busy  out  1  high from the cycle after start is accepted until DONE.
REQ-011 done  out  1  run complete; held until next accepted start.
REQ-012 pass  out  1  valid when done; 1 iff err_cnt == 0.
REQ-013 err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
REQ-014 fail_addr  out  ADDR_WIDTH  address of first mismatch of the run.
REQ-015 fail_data  out  DATA_WIDTH  rdata captured at first mismatch.
REQ-016 we, re  out  1 each  write/read enables to RAM, active-high.
REQ-017 byteen  out  BYTEEN_WIDTH  all ones whenever we = 1, else zero.
REQ-018 waddr, raddr  out  ADDR_WIDTH  RAM write/read addresses.
REQ-019 wdata  out  DATA_WIDTH  RAM write data.
REQ-020 rdata  in  DATA_WIDTH  RAM read data.

Function
REQ-021 States: IDLE, WRITE, READ, DRAIN, NEXT, DONE.
REQ-022 IDLE/DONE + start=1 with pattern_mask != 0 -> WRITE on lowest enabled pattern; err_cnt, fail_addr, fail_data, done, pass cleared.
REQ-023 start with pattern_mask == 0 -> DONE next cycle, pass=1, err_cnt=0.
REQ-024 start while busy ignored; pattern_mask latched at acceptance, later changes ignored.
REQ-025 WRITE: one write per cycle, waddr 0..DEPTH-1 ascending, we=1, exactly DEPTH cycles, then READ.
REQ-026 READ: one read per cycle, raddr 0..DEPTH-1 ascending, re=1, exactly DEPTH cycles, then DRAIN.
REQ-027 DRAIN: we=re=0 for READ_LATENCY cycles, then NEXT.
REQ-028 NEXT: one cycle; next higher enabled pattern -> WRITE, none left -> DONE.
REQ-029 Pattern data at address a: address = a zero-extended/truncated to DATA_WIDTH; checkerboard = {alternating 10} if a[0]=0 else {alternating 01}; inverse = bitwise NOT of checkerboard; LFSR = 32-bit Galois LFSR (taps 32,22,2,1) reseeded to LFSR_SEED at start of WRITE and of READ, advanced once per access, word formed by concatenating successive low 32-bit states truncated to DATA_WIDTH — identical sequence in both phases.
REQ-030 Compare pipeline: each read carries {addr, expected} through a READ_LATENCY-stage shift register; rdata compared when the stage output is valid.
REQ-031 Mismatch: err_cnt += 1 (saturating); on first mismatch of the run, fail_addr/fail_data captured, never overwritten later.
REQ-032 done/pass updated on entry to DONE; busy=0 in IDLE and DONE.
REQ-033 Outside WRITE: we=0, byteen=0, wdata=0. Outside READ: re=0.
REQ-034 Timing, single pattern, start sampled at cycle 0: WRITE cycles 1..DEPTH, READ DEPTH+1..2*DEPTH, DRAIN next READ_LATENCY cycles, NEXT one cycle, done=1 from cycle 2*DEPTH+READ_LATENCY+2.

Reset
REQ-035 rst=1 (any time, incl. mid-run) -> IDLE; busy, done, pass, we, re, byteen, waddr, raddr, wdata, err_cnt, fail_addr, fail_data, compare pipeline all zero.
REQ-036 First start after rst release runs from pattern start; no residue from an interrupted run.

Verification
REQ-037 Ideal RAM model, DATA_WIDTH=16, ADDR_WIDTH=4, READ_LATENCY=1, mask=4'b0001 -> 16 writes wdata=addr, 16 reads, done=1 at cycle 35, pass=1, err_cnt=0.
REQ-038 Model bit0 stuck-at-0 at address 5, mask=4'b0010 -> err_cnt=1, fail_addr=5, fail_data=16'h5554, pass=0.
REQ-039 Same fault, mask=4'b1111 -> patterns run in order 0,1,2,3; fail_addr=5 (from address pattern), fail_data=16'h0004, err_cnt equals count of patterns whose address-5 word has bit0=1.
REQ-040 READ_LATENCY=2 with registered-output RAM model, mask=4'b1000 -> pass=1, done=1 at cycle 36.
REQ-041 rst pulsed during READ of pattern 1 -> all outputs zero next edge; subsequent start with mask=4'b0001 -> clean pass.
REQ-042 start held high throughout run and mask=0 case -> no restart while busy; mask=0 gives done=1, pass=1 one cycle after start.

Source files
------------

// File: rtl/bram_bist_ctrl.sv
// rtl/bram_bist_ctrl.sv - BRAM built-in self-test controller
// Runs write-all/read-all passes per enabled data pattern and tallies read mismatches.
module bram_bist_ctrl #(
    parameter int          DATA_WIDTH   = 16,
    parameter int          ADDR_WIDTH   = 4,
    parameter int          BYTEEN_WIDTH = 2,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] LFSR_SEED    = 32'h1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              pattern_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_cnt,
    output logic [ADDR_WIDTH-1:0]   fail_addr,
    output logic [DATA_WIDTH-1:0]   fail_data,
    output logic                    we,
    output logic                    re,
    output logic [BYTEEN_WIDTH-1:0] byteen,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata
);

    localparam int PW    = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int PIPEW = READ_LATENCY * PW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [3:0]              mask_q;
    logic [1:0]              pidx;
    logic [31:0]             lfsr;
    logic [DATA_WIDTH-1:0]   rexp;
    logic [1:0]              drain_cnt;
    logic [PIPEW-1:0]        pipe;

    logic [PW-1:0]           tail;
    logic                    tail_vld;
    logic [ADDR_WIDTH-1:0]   tail_addr;
    logic [DATA_WIDTH-1:0]   tail_exp;
    logic [2:0]              first_pat;
    logic [2:0]              after_pat;

    // Galois form, taps 32,22,2,1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Words wider than 32 bits take successive states in ascending 32-bit slices.
    function automatic logic [DATA_WIDTH-1:0] lfsr_word(input logic [31:0] s);
        logic [DATA_WIDTH-1:0] w;
        logic [31:0]           t;
        w = '0;
        t = s;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w[i] = t[i % 32];
            if ((i % 32) == 31) t = lfsr_step(t);
        end
        return w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern_word(
        input logic [1:0]            p,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [31:0]           s
    );
        logic [DATA_WIDTH+ADDR_WIDTH-1:0] ax;
        logic [DATA_WIDTH-1:0]            cb;
        logic [DATA_WIDTH-1:0]            w;
        ax = {{DATA_WIDTH{1'b0}}, a};
        cb = '0;
        for (int i = 0; i < DATA_WIDTH; i++) cb[i] = i[0] ^ a[0];
        case (p)
            2'd0:    w = ax[DATA_WIDTH-1:0];
            2'd1:    w = cb;
            2'd2:    w = ~cb;
            default: w = lfsr_word(s);
        endcase
        return w;
    endfunction

    // Lowest enabled pattern at or above 'from'; 3'd4 means none left.
    function automatic logic [2:0] next_pat(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = 3'(i);
        end
        return r;
    endfunction

    assign tail      = pipe[PIPEW-1 -: PW];
    assign tail_vld  = tail[PW-1];
    assign tail_addr = tail[PW-2 -: ADDR_WIDTH];
    assign tail_exp  = tail[DATA_WIDTH-1:0];
    assign first_pat = next_pat(pattern_mask, 3'd0);
    assign after_pat = next_pat(mask_q, {1'b0, pidx} + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            pidx      <= '0;
            lfsr      <= '0;
            rexp      <= '0;
            drain_cnt <= '0;
            pipe      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            we        <= 1'b0;
            re        <= 1'b0;
            byteen    <= '0;
            waddr     <= '0;
            raddr     <= '0;
            wdata     <= '0;
        end else begin
            // Each issued read travels with its address and expected word until rdata is valid.
            pipe <= (pipe << PW) | PIPEW'({re, raddr, rexp});
            if (tail_vld && (tail_exp != rdata)) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'd0) begin
                    fail_addr <= tail_addr;
                    fail_data <= rdata;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        mask_q    <= pattern_mask;
                        if (pattern_mask == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state  <= S_WRITE;
                            busy   <= 1'b1;
                            pidx   <= first_pat[1:0];
                            we     <= 1'b1;
                            byteen <= '1;
                            waddr  <= '0;
                            wdata  <= pattern_word(first_pat[1:0], '0, LFSR_SEED);
                            lfsr   <= lfsr_step(LFSR_SEED);
                        end
                    end
                end
                S_WRITE: begin
                    if (waddr == {ADDR_WIDTH{1'b1}}) begin
                        state  <= S_READ;
                        we     <= 1'b0;
                        byteen <= '0;
                        wdata  <= '0;
                        re     <= 1'b1;
                        raddr  <= '0;
                        rexp   <= pattern_word(pidx, '0, LFSR_SEED);
                        lfsr   <= lfsr_step(LFSR_SEED);
                    end else begin
                        waddr <= waddr + 1'b1;
                        wdata <= pattern_word(pidx, waddr + 1'b1, lfsr);
                        lfsr  <= lfsr_step(lfsr);
                    end
                end
                S_READ: begin
                    if (raddr == {ADDR_WIDTH{1'b1}}) begin
                        state     <= S_DRAIN;
                        re        <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        raddr <= raddr + 1'b1;
                        rexp  <= pattern_word(pidx, raddr + 1'b1, lfsr);
                        lfsr  <= lfsr_step(lfsr);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'(READ_LATENCY - 1)) state <= S_NEXT;
                    else                                   drain_cnt <= drain_cnt + 2'd1;
                end
                S_NEXT: begin
                    if (after_pat[2]) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 16'd0);
                    end else begin
                        state  <= S_WRITE;
                        pidx   <= after_pat[1:0];
                        we     <= 1'b1;
                        byteen <= '1;
                        waddr  <= '0;
                        wdata  <= pattern_word(after_pat[1:0], '0, LFSR_SEED);
                        lfsr   <= lfsr_step(LFSR_SEED);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// tb/tb_bram_bist_ctrl.sv - self-checking bench for bram_bist_ctrl
// Two instances (read latency 1 and 2) each driving a behavioural RAM with an optional stuck-at-0 cell.
module tb_bram_bist_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic fault_en;
    logic [3:0] fault_addr, fault_bit;

    logic start1, busy1, done1, pass1, we1, re1;
    logic [3:0] mask1;
    logic [15:0] err_cnt1;
    logic [AW-1:0] fail_addr1, waddr1, raddr1;
    logic [DW-1:0] fail_data1, wdata1, rdata1;
    logic [1:0] byteen1;

    logic start2, busy2, done2, pass2, we2, re2;
    logic [3:0] mask2;
    logic [15:0] err_cnt2;
    logic [AW-1:0] fail_addr2, waddr2, raddr2;
    logic [DW-1:0] fail_data2, wdata2, rdata2, rpipe2;
    logic [1:0] byteen2;

    logic [DW-1:0] mem1 [D];
    logic [DW-1:0] mem2 [D];
    logic [15:0]   lfsr_tab [D];

    int checks = 0;
    int errors = 0;

    bram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(2), .READ_LATENCY(1), .LFSR_SEED(32'h1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pattern_mask(mask1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err_cnt1), .fail_addr(fail_addr1), .fail_data(fail_data1),
        .we(we1), .re(re1), .byteen(byteen1), .waddr(waddr1), .raddr(raddr1), .wdata(wdata1), .rdata(rdata1));

    bram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(2), .READ_LATENCY(2), .LFSR_SEED(32'h1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pattern_mask(mask2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err_cnt2), .fail_addr(fail_addr2), .fail_data(fail_data2),
        .we(we2), .re(re2), .byteen(byteen2), .waddr(waddr2), .raddr(raddr2), .wdata(wdata2), .rdata(rdata2));

    function automatic logic [DW-1:0] stuck(input logic [DW-1:0] d, input logic [AW-1:0] a);
        return (fault_en && a == fault_addr) ? (d & ~(16'h1 << fault_bit)) : d;
    endfunction

    function automatic logic [DW-1:0] bemask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge clk) begin
        if (we1) mem1[waddr1] <= (mem1[waddr1] & ~bemask(byteen1)) | (stuck(wdata1, waddr1) & bemask(byteen1));
        if (re1) rdata1 <= mem1[raddr1];
        if (we2) mem2[waddr2] <= (mem2[waddr2] & ~bemask(byteen2)) | (stuck(wdata2, waddr2) & bemask(byteen2));
        if (re2) rpipe2 <= mem2[raddr2];
        rdata2 <= rpipe2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int p, input int a);
        case (p)
            0:       return 16'(a);
            1:       return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
            2:       return (a % 2 == 1) ? 16'hAAAA : 16'h5555;
            default: return lfsr_tab[a];
        endcase
    endfunction

    function automatic int nth_pat(input logic [3:0] m, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic model(input logic [3:0] m, output int errs, output int fa, output logic [15:0] fd, output int npat);
        logic [15:0] w, r;
        errs = 0; fa = 0; fd = '0; npat = 0;
        for (int p = 0; p < 4; p++) begin
            if (m[p]) begin
                npat++;
                for (int a = 0; a < D; a++) begin
                    w = exp_word(p, a);
                    r = (fault_en && a == int'(fault_addr)) ? (w & ~(16'h1 << fault_bit)) : w;
                    if (r != w) begin
                        if (errs == 0) begin fa = a; fd = r; end
                        errs++;
                    end
                end
            end
        end
    endtask

    task automatic run1(input logic [3:0] m, input bit hold);
        int errs, fa, npat, done_cyc, seg, off, p;
        logic [15:0] fd;
        logic [29:0] expv, obsv;
        model(m, errs, fa, fd, npat);
        done_cyc = (npat == 0) ? 1 : npat * (2 * D + 2) + 1;
        @(negedge clk);
        start1 = 1'b1;
        mask1  = m;
        @(posedge clk);
        for (int k = 1; k <= done_cyc; k++) begin
            @(negedge clk);
            if (!hold) start1 = 1'b0;
            mask1 = 4'($urandom_range(0, 15));
            expv = '0;
            if (k < done_cyc) begin
                seg = (k - 1) / (2 * D + 2);
                off = (k - 1) % (2 * D + 2);
                p   = nth_pat(m, seg);
                expv[29] = 1'b1;
                if (off < D) begin
                    expv[27]    = 1'b1;
                    expv[25:24] = 2'b11;
                    expv[23:20] = 4'(off);
                    expv[15:0]  = exp_word(p, off);
                end else if (off < 2 * D) begin
                    expv[26]    = 1'b1;
                    expv[19:16] = 4'(off - D);
                end
            end else begin
                expv[28] = 1'b1;
            end
            obsv = {busy1, done1, we1, re1, byteen1, we1 ? waddr1 : 4'h0, re1 ? raddr1 : 4'h0, wdata1};
            check($sformatf("cycle%0d_mask%0h", k, m), 64'(obsv), 64'(expv));
        end
        start1 = 1'b0;
        check("err_cnt", 64'(err_cnt1), 64'(errs));
        check("pass", 64'(pass1), 64'(errs == 0));
        check("fail_addr", 64'(fail_addr1), 64'(fa));
        check("fail_data", 64'(fail_data1), 64'(fd));
        repeat (2) @(negedge clk);
        check("done_hold", 64'({done1, busy1}), 64'(2'b10));
    endtask

    task automatic run2(input logic [3:0] m);
        int errs, fa, npat, done_cyc, first;
        logic [15:0] fd;
        model(m, errs, fa, fd, npat);
        done_cyc = (npat == 0) ? 1 : npat * (2 * D + 3) + 1;
        first = 0;
        @(negedge clk);
        start2 = 1'b1;
        mask2  = m;
        @(posedge clk);
        for (int k = 1; k <= done_cyc + 3; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2 && first == 0) first = k;
        end
        check("rl2_done_cycle", 64'(first), 64'(done_cyc));
        check("rl2_err_cnt", 64'(err_cnt2), 64'(errs));
        check("rl2_pass", 64'(pass2), 64'(errs == 0));
        check("rl2_fail_addr", 64'(fail_addr2), 64'(fa));
        check("rl2_fail_data", 64'(fail_data2), 64'(fd));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({busy1, done1, pass1, we1, re1, byteen1, waddr1, raddr1}), 64'h0);
        check({tag, "_dat"}, 64'({err_cnt1, fail_addr1, fail_data1, wdata1}), 64'h0);
    endtask

    initial begin
        logic [31:0] s;
        s = 32'h1;
        for (int a = 0; a < D; a++) begin
            lfsr_tab[a] = s[15:0];
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mask1 = '0; mask2 = '0;
        fault_en = 1'b0; fault_addr = '0; fault_bit = '0;
        repeat (3) @(negedge clk);
        check_zero("reset1");
        check("reset2", 64'({busy2, done2, pass2, we2, re2, err_cnt2}), 64'h0);
        rst = 1'b0;

        run1(4'b0001, 1'b0);

        fault_en = 1'b1; fault_addr = 4'd5; fault_bit = 4'd0;
        run1(4'b0010, 1'b0);
        check("stuck_cb_err", 64'(err_cnt1), 64'd1);
        check("stuck_cb_addr", 64'(fail_addr1), 64'd5);
        check("stuck_cb_data", 64'(fail_data1), 64'h5554);

        run1(4'b1111, 1'b1);
        check("stuck_all_addr", 64'(fail_addr1), 64'd5);
        check("stuck_all_data", 64'(fail_data1), 64'h0004);

        run1(4'b0000, 1'b1);

        repeat (6) begin
            fault_en   = 1'($urandom_range(0, 1));
            fault_addr = 4'($urandom_range(0, 15));
            fault_bit  = 4'($urandom_range(0, 15));
            run1(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        fault_en = 1'b0;
        run2(4'b1000);
        repeat (3) begin
            fault_en   = 1'b1;
            fault_addr = 4'($urandom_range(0, 15));
            fault_bit  = 4'($urandom_range(0, 15));
            run2(4'($urandom_range(1, 15)));
        end

        fault_en = 1'b1; fault_addr = 4'd5; fault_bit = 4'd0;
        @(negedge clk);
        start1 = 1'b1;
        mask1  = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (2 * D + 2 + D + 3) @(negedge clk);
        check("pre_rst_reading", 64'({re1, busy1}), 64'(2'b11));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        fault_en = 1'b0;
        run1(4'b0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
